// File: rtl/position_divider_scheduler.sv
// Position divider scheduler: shares one pipelined divider among the TBT, FA
// and SA magnitude sources. Toggle requests are edge-detected, arbitrated with
// fixed priority (TBT > FA > SA), and each grant sequences a magnitude latch,
// operand fill cycles and three divider beats (X, Y, Q) under credit control.
// Per-source 3-bit vectors (match/pending/overrun/enable) use bit 2 = TBT,
// bit 1 = FA, bit 0 = SA, matching the csr field order.
module position_divider_scheduler #(
    parameter int FILL_CYCLES     = 3,
    parameter int MAX_OUTSTANDING = 8,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tbtInToggle,
    input  logic                  faInToggle,
    input  logic                  saInToggle,
    input  logic [DATA_WIDTH-1:0] gpioData,
    input  logic                  csrStrobe,
    output logic [DATA_WIDTH-1:0] csr,
    output logic                  srcLoad,
    output logic [1:0]            srcSelect,
    output logic [1:0]            opSelect,
    output logic                  opValid,
    input  logic                  opReady,
    input  logic                  resultValid,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_ISSUE} state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_match, r_pending, r_overrun, r_enable;
    logic       r_underflow;
    logic [3:0] r_out, w_out_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       r_srcLoad, w_srcLoad_nxt;
    logic [1:0] r_srcSel, w_srcSel_nxt;
    logic [1:0] r_opSel, w_opSel_nxt;
    logic       r_opValid, w_opValid_nxt;
    logic [2:0] w_tog, w_req, w_gnt_oh, w_ovr_clr;
    logic [1:0] w_gnt_code;
    logic       w_acc, w_ret, w_uf, w_room, w_uf_clr;
    logic       w_unused_gpio;

    assign w_tog     = {tbtInToggle, faInToggle, saInToggle};
    assign w_req     = (w_tog ^ r_match) & r_enable;
    assign w_acc     = r_opValid & opReady;
    // A return with nothing outstanding is an underflow unless a beat is
    // accepted in the same cycle (net count is unchanged then).
    assign w_uf      = resultValid & ~w_acc & (r_out == 4'd0);
    assign w_ret     = resultValid & ~w_uf;
    assign w_room    = w_out_nxt < 4'(MAX_OUTSTANDING);
    assign w_ovr_clr = csrStrobe ? gpioData[31:29] : 3'b000;
    assign w_uf_clr  = csrStrobe & gpioData[28];
    assign w_unused_gpio = ^gpioData;

    // Next credit count: +1 per accepted beat, -1 per returned quotient.
    always_comb begin
        w_out_nxt = r_out;
        if (w_acc && !w_ret)      w_out_nxt = r_out + 4'd1;
        else if (!w_acc && w_ret) w_out_nxt = r_out - 4'd1;
    end

    // Fixed-priority encode of pending requests: TBT > FA > SA.
    always_comb begin
        w_gnt_code = 2'd2;
        if (r_pending[2])      w_gnt_code = 2'd0;
        else if (r_pending[1]) w_gnt_code = 2'd1;
    end

    // Request detect, sticky status, enables and credit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_match     <= w_tog;
            r_pending   <= 3'b000;
            r_overrun   <= 3'b000;
            r_underflow <= 1'b0;
            r_enable    <= 3'b111;
            r_out       <= 4'd0;
        end else begin
            r_match     <= w_tog;
            r_pending   <= (r_pending & ~w_gnt_oh) | w_req;
            // An edge on the source being granted this cycle is a fresh
            // request, not an overrun.
            r_overrun   <= (r_overrun & ~w_ovr_clr) | (w_req & r_pending & ~w_gnt_oh);
            r_underflow <= (r_underflow & ~w_uf_clr) | w_uf;
            if (csrStrobe) r_enable <= gpioData[2:0];
            r_out       <= w_out_nxt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Registered sequencing outputs and fill counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= 3'd0;
            r_srcLoad <= 1'b0;
            r_srcSel  <= 2'd0;
            r_opSel   <= 2'd0;
            r_opValid <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_srcLoad <= w_srcLoad_nxt;
            r_srcSel  <= w_srcSel_nxt;
            r_opSel   <= w_opSel_nxt;
            r_opValid <= w_opValid_nxt;
        end
    end

    // Next-state and output decode. The fill counter is loaded with
    // FILL_CYCLES: the srcLoad cycle itself is spent in FILL ahead of the
    // FILL_CYCLES operand-pipeline cycles, so the first beat lands
    // FILL_CYCLES+1 cycles after srcLoad.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_srcLoad_nxt = 1'b0;
        w_srcSel_nxt  = r_srcSel;
        w_opSel_nxt   = r_opSel;
        w_opValid_nxt = r_opValid;
        w_gnt_oh      = 3'b000;
        case (r_state)
            S_IDLE: begin
                w_opValid_nxt = 1'b0;
                w_opSel_nxt   = 2'd0;
                if (|r_pending) begin
                    w_gnt_oh      = 3'b100 >> w_gnt_code;
                    w_srcSel_nxt  = w_gnt_code;
                    w_srcLoad_nxt = 1'b1;
                    w_cnt_nxt     = 3'(FILL_CYCLES);
                    w_state_nxt   = S_FILL;
                end
            end
            S_FILL: begin
                w_opSel_nxt = 2'd0;
                if (r_cnt == 3'd0) begin
                    w_opValid_nxt = w_room;
                    w_state_nxt   = S_ISSUE;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            S_ISSUE: begin
                if (w_acc) begin
                    if (r_opSel == 2'd2) begin
                        w_opValid_nxt = 1'b0;
                        w_opSel_nxt   = 2'd0;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_opSel_nxt   = r_opSel + 2'd1;
                        w_opValid_nxt = w_room;
                    end
                end else if (!r_opValid) begin
                    // Stalled on credits: raise valid once one is free.
                    w_opValid_nxt = w_room;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign srcLoad   = r_srcLoad;
    assign srcSelect = r_srcSel;
    assign opSelect  = r_opSel;
    assign opValid   = r_opValid;
    assign busy      = (r_state != S_IDLE);
    assign csr       = DATA_WIDTH'({r_overrun, r_underflow, 4'b0000, r_out,
                                    r_pending, r_enable, 14'b0});

endmodule
